ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, host command bytes,
// device reply codes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] PS2_REPLY_ACK     = 8'hFA;
  localparam logic [7:0] PS2_REPLY_RESEND  = 8'hFE;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus registered falling-edge
// detect. Idle level is high, so everything resets to 1 / no edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic fall_q;

  // Synchronize and flag the synchronized level going 1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      fall_q <= s2_q & ~s1_q;
    end
  end

  assign level_o = s2_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-collector line drivers).
// Optional macro PS2_TX_TIMEOUT_EN builds a watchdog on the device clock
// edges; without it the FSM waits for the device indefinitely.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_data_in),
    .level_o (data_lvl),
    .fall_o  (data_fall_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_timed;

  // Watchdog count since the last device clock edge (or since START entry).
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT_CYCLES;
`endif

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state plus next values of the registered line drivers and pulses.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          data_d    = tx_data;
          par_d     = odd_parity(tx_data);
          bit_d     = '0;
          cnt_d     = '0;
          data_oe_d = (INH_LAST == CNT_W'(0));
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = ST_START;
        end else begin
          cnt_d     = CNT_W'(cnt_q + 1'b1);
          data_oe_d = (cnt_d == INH_LAST);
        end
      end
      ST_START: begin
        if (clk_fall) begin
          data_oe_d = ~data_q[0];
          bit_d     = 4'd1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_fall) begin
          if (bit_q == 4'd8) begin
            data_oe_d = ~par_q;
            state_d   = ST_PARITY;
          end else begin
            data_oe_d = ~data_q[bit_q[2:0]];
            bit_d     = 4'(bit_q + 4'd1);
          end
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          if (!data_lvl) begin
            state_d = ST_ACK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_ACK: begin
        if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        data_oe_d = 1'b0;
        if (clk_lvl && data_lvl) state_d = ST_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_timed = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_PARITY) ||
               (state_q == ST_STOP)  || (state_q == ST_ACK);
    wd_d = (wd_timed && !clk_fall) ? WD_W'(wd_q + 1'b1) : '0;
    if (wd_timed && !clk_fall && (wd_q == WD_LAST)) begin
      // Device went silent: abandon the byte; takes priority over tx_done.
      done_d    = 1'b0;
      err_d     = 1'b1;
      data_oe_d = 1'b0;
      wd_d      = '0;
      state_d   = ST_IDLE;
    end
`endif

    clk_oe_d = (state_d == ST_INHIBIT);
    ready_d  = (state_d == ST_IDLE);
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-collector lines. Timeout scenario runs only with PS2_TX_TIMEOUT_EN.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 500;
  localparam int unsigned H   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_rel = 1'b1;
  logic       dev_data_rel = 1'b1;

  assign ps2_clk_in  = dev_clk_rel & ~ps2_clk_oe;
  assign ps2_data_in = dev_data_rel & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int run = 0, inh_len = 0, err_cyc = 0, last_fall_cyc = 0;
  logic last_doe = 1'b0, inh_start_bit = 1'b0;

  // Pulse counters and inhibit-window measurement.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) begin
      run      <= run + 1;
      last_doe <= ps2_data_oe;
    end else if (run != 0) begin
      inh_len       <= run;
      inh_start_bit <= last_doe;
      run           <= 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input logic val, input string tag);
    int n = 0;
    while (tx_ready !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_ready), 32'(val));
  endtask

  task automatic wait_clk_oe(input logic val, input string tag);
    int n = 0;
    while (ps2_clk_oe !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(ps2_clk_oe), 32'(val));
  endtask

  // Device side: generate nfalls clock falls, capture start/data/parity/stop.
  task automatic dev_xfer(input int nfalls, input bit ack, output logic [10:0] frame);
    frame = '1;
    wait_clk_oe(1'b1, "inhibit_begin");
    wait_clk_oe(1'b0, "inhibit_end");
    repeat (H) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack) begin
        dev_data_rel = 1'b0;
        repeat (5) @(negedge clk);
      end
      dev_clk_rel   = 1'b0;
      last_fall_cyc = cyc;
      repeat (H) @(negedge clk);
      if (k <= 10) frame[k] = ps2_data_in;
      dev_clk_rel = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_data_rel = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic full_xfer(input logic [7:0] b, input bit ack, input logic [10:0] exp_frame,
                           input string tag);
    int d0, e0;
    logic [10:0] fr;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    dev_xfer(11, ack, fr);
    wait_ready(1'b1, {tag, "_ready"});
    repeat (3) @(negedge clk);
    chk({tag, "_frame"}, 32'(fr), 32'(exp_frame));
    chk({tag, "_inhibit_len"}, 32'(inh_len), 32'(INH));
    chk({tag, "_start_in_inhibit"}, 32'(inh_start_bit), 32'd1);
    chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [10:0] fr;
    int d0, e0;
    $display("info: device reply codes ack=%h resend=%h", PS2_REPLY_ACK, PS2_REPLY_RESEND);

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Normal ACKed transfers, frame = {stop, parity, data, start}
    full_xfer(PS2_CMD_SET_LEDS, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, "ed");
    full_xfer(8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, "x00");
    full_xfer(PS2_CMD_RESET, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, "xff");
    full_xfer(8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, "x01");

    // Device does not ACK
    full_xfer(PS2_CMD_SET_LEDS, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, "nack");

    // Reset in the middle of DATA (bit 4 of 8'hED is 0 -> data line pulled)
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(PS2_CMD_SET_LEDS);
    dev_xfer(5, 1'b0, fr);
    chk("mid_partial_bits", 32'(fr[5:0]), 32'b011010);
    chk("mid_pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    chk("mid_pre_rst_ready", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
    full_xfer(PS2_CMD_RESET, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, "post_rst");

    // tx_valid held across a transfer with tx_data changing
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tx_data  = PS2_CMD_ENABLE;
    tx_valid = 1'b1;
    wait_ready(1'b0, "hold_accept1");
    tx_data = 8'hFF;
    dev_xfer(11, 1'b1, fr);
    chk("hold_frame1", 32'(fr), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    wait_ready(1'b1, "hold_ready_again");
    wait_ready(1'b0, "hold_accept2");
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, fr);
    chk("hold_frame2", 32'(fr), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    wait_ready(1'b1, "hold_ready_end");
    repeat (20) @(negedge clk);
    chk("hold_done", 32'(done_cnt - d0), 32'd2);
    chk("hold_err", 32'(err_cnt - e0), 32'd0);
    chk("hold_idle_ready", 32'(tx_ready), 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
    // Device stops clocking after bit 3
    begin
      int n;
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'h00);
      dev_xfer(4, 1'b0, fr);
      chk("tmo_pre_data_oe", 32'(ps2_data_oe), 32'd1);
      n = 0;
      while (err_cnt == e0 && n < int'(TMO) + 200) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      chk("tmo_err", 32'(err_cnt - e0), 32'd1);
      chk("tmo_latency_ok",
          32'((err_cyc - last_fall_cyc >= int'(TMO)) && (err_cyc - last_fall_cyc <= int'(TMO) + 8)),
          32'd1);
      chk("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
      chk("tmo_ready", 32'(tx_ready), 32'd1);
      chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    end
`endif

    chk("never_done_and_err", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
